// File: rtl/pc_sequencer.sv
// Two-state fetch/hold program-counter sequencer driving an external PC incrementer.
// Optional link register for jump-and-link is built when PC_SEQ_LINK_EN is defined.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        stall,
  input  logic        br_take,
  input  logic [15:0] br_disp,
  input  logic        jmp_take,
  input  logic [15:0] jmp_addr,
  output logic [15:0] pc,
`ifdef PC_SEQ_LINK_EN
  input  logic        link_take,
  output logic [15:0] link_addr,
`endif
  output logic [15:0] incr_curr_pc,
  output logic        incr_decr,
  output logic [15:0] incr_diff,
  input  logic [15:0] incr_next_pc
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] pc_r;
  logic [15:0] instr_r;
  logic        instr_valid_r;
  logic        imem_req_s;
  logic        accept_s;
  logic        incr_decr_s;
  logic [15:0] incr_diff_s;

  assign accept_s = (state_r == ST_HOLD) && instr_ack && !stall;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (imem_valid) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: state_s = ST_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req_s = 1'b0;
    case (state_r)
      ST_FETCH: imem_req_s = 1'b1;
      ST_HOLD:  imem_req_s = 1'b0;
      default:  imem_req_s = 1'b0;
    endcase
  end

  // Datapath registers: instruction capture and PC redirect on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= 16'h0000;
      instr_r       <= 16'h0000;
      instr_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_valid) begin
            instr_r       <= imem_data;
            instr_valid_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            pc_r          <= jmp_take ? jmp_addr : incr_next_pc;
            instr_valid_r <= 1'b0;
          end
        end
        default: instr_valid_r <= 1'b0;
      endcase
    end
  end

  // Incrementer operands: magnitude/direction of a taken branch, else +1
  always_comb begin
    incr_decr_s = 1'b0;
    incr_diff_s = 16'h0001;
    if (br_take && !jmp_take) begin
      incr_decr_s = br_disp[15];
      if (br_disp[15]) begin
        incr_diff_s = (~br_disp) + 16'h0001;
      end else begin
        incr_diff_s = br_disp;
      end
    end else begin
      incr_decr_s = 1'b0;
      incr_diff_s = 16'h0001;
    end
  end

`ifdef PC_SEQ_LINK_EN
  logic [15:0] link_addr_r;

  // Link register captures the return address (pc+1) on a linking jump
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_addr_r <= 16'h0000;
    end else if (accept_s && jmp_take && link_take) begin
      link_addr_r <= incr_next_pc;
    end
  end

  assign link_addr = link_addr_r;
`endif

  assign imem_req     = imem_req_s;
  assign imem_addr    = pc_r;
  assign pc           = pc_r;
  assign instr        = instr_r;
  assign instr_valid  = instr_valid_r;
  assign incr_curr_pc = pc_r;
  assign incr_decr    = incr_decr_s;
  assign incr_diff    = incr_diff_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a behavioural PC incrementer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        stall = 1'b0;
  logic        br_take = 1'b0;
  logic [15:0] br_disp = 16'h0000;
  logic        jmp_take = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
  logic [15:0] pc;
  logic [15:0] incr_curr_pc;
  logic        incr_decr;
  logic [15:0] incr_diff;
  logic [15:0] incr_next_pc;
`ifdef PC_SEQ_LINK_EN
  logic        link_take = 1'b0;
  logic [15:0] link_addr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign incr_next_pc = incr_decr ? (incr_curr_pc - incr_diff) : (incr_curr_pc + incr_diff);

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack),
    .stall        (stall),
    .br_take      (br_take),
    .br_disp      (br_disp),
    .jmp_take     (jmp_take),
    .jmp_addr     (jmp_addr),
    .pc           (pc),
`ifdef PC_SEQ_LINK_EN
    .link_take    (link_take),
    .link_addr    (link_addr),
`endif
    .incr_curr_pc (incr_curr_pc),
    .incr_decr    (incr_decr),
    .incr_diff    (incr_diff),
    .incr_next_pc (incr_next_pc)
  );

  // Called at a negedge in FETCH; returns at the next negedge (now in HOLD).
  task automatic fetch_word(input logic [15:0] d);
    imem_valid = 1'b1;
    imem_data  = d;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
  endtask

  // Called at a negedge in HOLD; accepts and returns at the next negedge (now in FETCH).
  task automatic accept(input logic jt, input logic [15:0] ja, input logic bt, input logic [15:0] bd);
    instr_ack = 1'b1;
    jmp_take  = jt;
    jmp_addr  = ja;
    br_take   = bt;
    br_disp   = bd;
    @(negedge clk);
    instr_ack = 1'b0;
    jmp_take  = 1'b0;
    jmp_addr  = 16'h0000;
    br_take   = 1'b0;
    br_disp   = 16'h0000;
  endtask

  task automatic goto_addr(input logic [15:0] a);
    fetch_word(16'h0000);
    accept(1'b1, a, 1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 16'h0000); end
    n_cmp++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, 16'h0000); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", instr_valid, 1'b0); end
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b expected %b", imem_req, 1'b1); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d]: got %b expected %b", i, imem_req, 1'b1); end
      n_cmp++; if (imem_addr !== 16'(i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 16'(i)); end
      fetch_word(16'hA000 + 16'(i));
      n_cmp++; if (instr !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr, 16'hA000 + 16'(i)); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected %b", i, instr_valid, 1'b1); end
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_hold_req[%0d]: got %b expected %b", i, imem_req, 1'b0); end
      n_cmp++; if (incr_diff !== 16'h0001 || incr_decr !== 1'b0) begin n_fail++; $display("FAIL seq_incr[%0d]: got %b/%h expected 0/0001", i, incr_decr, incr_diff); end
      accept(1'b0, 16'h0000, 1'b0, 16'h0000);
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_clear[%0d]: got %b expected %b", i, instr_valid, 1'b0); end
    end
    n_cmp++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL seq_pc_end: got %h expected %h", pc, 16'h0003); end
  endtask

  task automatic test_ignored();
    instr_ack = 1'b1; jmp_take = 1'b1; jmp_addr = 16'h5555;
    @(negedge clk);
    instr_ack = 1'b0; jmp_take = 1'b0; jmp_addr = 16'h0000;
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ign_fetch_req: got %b expected %b", imem_req, 1'b1); end
    n_cmp++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL ign_fetch_pc: got %h expected %h", pc, 16'h0003); end
    fetch_word(16'h1111);
    imem_valid = 1'b1; imem_data = 16'h2222;
    @(negedge clk);
    imem_valid = 1'b0; imem_data = 16'h0000;
    n_cmp++; if (instr !== 16'h1111) begin n_fail++; $display("FAIL ign_hold_instr: got %h expected %h", instr, 16'h1111); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ign_hold_valid: got %b expected %b", instr_valid, 1'b1); end
    accept(1'b0, 16'h0000, 1'b0, 16'h0000);
    n_cmp++; if (imem_addr !== 16'h0004) begin n_fail++; $display("FAIL ign_next: got %h expected %h", imem_addr, 16'h0004); end
  endtask

  task automatic test_branch();
    goto_addr(16'h0010);
    fetch_word(16'h0B00);
    instr_ack = 1'b1; br_take = 1'b1; br_disp = 16'hFFFC;
    #1;
    n_cmp++; if (incr_decr !== 1'b1) begin n_fail++; $display("FAIL br_neg_decr: got %b expected %b", incr_decr, 1'b1); end
    n_cmp++; if (incr_diff !== 16'h0004) begin n_fail++; $display("FAIL br_neg_diff: got %h expected %h", incr_diff, 16'h0004); end
    n_cmp++; if (incr_curr_pc !== 16'h0010) begin n_fail++; $display("FAIL br_curr_pc: got %h expected %h", incr_curr_pc, 16'h0010); end
    accept(1'b0, 16'h0000, 1'b1, 16'hFFFC);
    n_cmp++; if (imem_addr !== 16'h000C) begin n_fail++; $display("FAIL br_neg_next: got %h expected %h", imem_addr, 16'h000C); end
    fetch_word(16'h0B01);
    br_take = 1'b1; br_disp = 16'h8000;
    #1;
    n_cmp++; if (incr_decr !== 1'b1 || incr_diff !== 16'h8000) begin n_fail++; $display("FAIL br_min_ops: got %b/%h expected 1/8000", incr_decr, incr_diff); end
    accept(1'b0, 16'h0000, 1'b1, 16'h8000);
    n_cmp++; if (imem_addr !== 16'h800C) begin n_fail++; $display("FAIL br_min_next: got %h expected %h", imem_addr, 16'h800C); end
    fetch_word(16'h0B02);
    br_take = 1'b1; br_disp = 16'h0005;
    #1;
    n_cmp++; if (incr_decr !== 1'b0 || incr_diff !== 16'h0005) begin n_fail++; $display("FAIL br_pos_ops: got %b/%h expected 0/0005", incr_decr, incr_diff); end
    accept(1'b0, 16'h0000, 1'b1, 16'h0005);
    n_cmp++; if (imem_addr !== 16'h8011) begin n_fail++; $display("FAIL br_pos_next: got %h expected %h", imem_addr, 16'h8011); end
    goto_addr(16'h0002);
    fetch_word(16'h0B03);
    accept(1'b0, 16'h0000, 1'b1, 16'hFFFC);
    n_cmp++; if (imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL br_wrap_next: got %h expected %h", imem_addr, 16'hFFFE); end
  endtask

  task automatic test_jump_over_branch();
    fetch_word(16'h0C00);
    jmp_take = 1'b1; br_take = 1'b1; br_disp = 16'hFFF0;
    #1;
    n_cmp++; if (incr_decr !== 1'b0 || incr_diff !== 16'h0001) begin n_fail++; $display("FAIL jmp_ops: got %b/%h expected 0/0001", incr_decr, incr_diff); end
    accept(1'b1, 16'h1234, 1'b1, 16'hFFF0);
    n_cmp++; if (imem_addr !== 16'h1234) begin n_fail++; $display("FAIL jmp_next: got %h expected %h", imem_addr, 16'h1234); end
  endtask

  task automatic test_stall_wrap();
    goto_addr(16'hFFFF);
    fetch_word(16'hBEEF);
    instr_ack = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 16'hFFFF); end
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'hBEEF) begin n_fail++; $display("FAIL stall_instr[%0d]: got %b/%h expected 1/beef", i, instr_valid, instr); end
    end
    stall = 1'b0;
    @(negedge clk);
    instr_ack = 1'b0;
    n_cmp++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_wrap_next: got %b/%h expected 1/0000", imem_req, imem_addr); end
  endtask

`ifdef PC_SEQ_LINK_EN
  task automatic test_link();
    goto_addr(16'h0020);
    fetch_word(16'h0D00);
    link_take = 1'b1;
    accept(1'b1, 16'h0100, 1'b0, 16'h0000);
    link_take = 1'b0;
    n_cmp++; if (link_addr !== 16'h0021) begin n_fail++; $display("FAIL link_addr: got %h expected %h", link_addr, 16'h0021); end
    n_cmp++; if (imem_addr !== 16'h0100) begin n_fail++; $display("FAIL link_next: got %h expected %h", imem_addr, 16'h0100); end
    fetch_word(16'h0D01);
    link_take = 1'b1;
    accept(1'b0, 16'h0000, 1'b0, 16'h0000);
    link_take = 1'b0;
    n_cmp++; if (link_addr !== 16'h0021) begin n_fail++; $display("FAIL link_hold: got %h expected %h", link_addr, 16'h0021); end
  endtask
`endif

  task automatic test_reset_mid();
    goto_addr(16'h0040);
    @(negedge clk);
    n_cmp++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rstmid_pre: got %h expected %h", imem_addr, 16'h0040); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 16'h0000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_fetch: got %h/%b expected 0000/0", pc, instr_valid); end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_first: got %b/%h expected 1/0000", imem_req, imem_addr); end
    goto_addr(16'h0040);
    fetch_word(16'h7777);
    instr_ack = 1'b1; jmp_take = 1'b1; jmp_addr = 16'h0300;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || pc !== 16'h0000) begin n_fail++; $display("FAIL rstmid_hold: got %b/%h/%h expected 0/0000/0000", instr_valid, instr, pc); end
    @(negedge clk);
    instr_ack = 1'b0; jmp_take = 1'b0; jmp_addr = 16'h0000;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold_first: got %b/%h expected 1/0000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ignored();
    test_branch();
    test_jump_over_branch();
    test_stall_wrap();
`ifdef PC_SEQ_LINK_EN
    test_link();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_addr  output  16  fetch address.
REQ-006 imem_valid  input  1  fetch data valid.
REQ-007 imem_data  input  16  fetched instruction word.
REQ-008 instr  output  16  held instruction for decode.
REQ-009 instr_valid  output  1  instr is valid.
REQ-010 instr_ack  input  1  decode consumes instr.
REQ-011 stall  input  1  blocks consumption while high.
REQ-012 br_take, br_disp  input  1, 16  relative branch request; br_disp is signed two's complement.
REQ-013 jmp_take, jmp_addr  input  1, 16  absolute jump request.
REQ-014 pc  output  16  current program counter.
REQ-015 incr_curr_pc, incr_decr, incr_diff  output  16, 1, 16  operands driven to the downstream PC incrementer.
REQ-016 incr_next_pc  input  16  incrementer result: curr_pc+diff, or curr_pc-diff when decr=1, modulo 2^16.

Function
REQ-017 There SHALL be two states: FETCH and HOLD.
REQ-018 FETCH: imem_req=1 and imem_addr=pc.
- imem_valid=1 latches imem_data into instr, sets instr_valid=1 and moves to HOLD on the next edge.
- While imem_valid=0, the block stays in FETCH.
REQ-019 HOLD: imem_req=0 and instr_valid=1.
- instr_ack=1 with stall=0 is an accept.
- On an accept, pc loads the redirect result, instr_valid clears and the state returns to FETCH on the same edge.
REQ-020 Redirect priority at accept: jmp_take, then br_take, then sequential.
- jmp_take: pc <= jmp_addr.
- Otherwise pc <= incr_next_pc.
REQ-021 Incrementer operands are combinational:
- incr_curr_pc = pc at all times.
- br_take=1 and jmp_take=0: incr_decr=br_disp[15]; incr_diff=|br_disp|, two's-complement negate when negative.
- br_disp=0x8000: diff=0x8000, decr=1.
- All other cases: decr=0, diff=1.
REQ-022 All PC arithmetic SHALL wrap modulo 2^16 (0xFFFF+1=0x0000; 0x0002 branch -4 = 0xFFFE).
REQ-023 imem_valid, instr_ack, br_take and jmp_take SHALL be ignored in any state where they are not sampled by REQ-018 to REQ-020.
REQ-024 stall=1 in HOLD SHALL hold pc, instr and instr_valid unchanged regardless of instr_ack.
REQ-025 Best-case throughput SHALL be one instruction per 2 cycles: imem_valid in the first FETCH cycle, followed by an accept in the first HOLD cycle.

Reset
REQ-026 Assertion of rst SHALL immediately and asynchronously set:
- pc=0x0000, instr=0x0000, instr_valid=0;
- state FETCH;
- link_addr=0x0000 when present.
REQ-027 Reset mid-fetch or mid-hold SHALL discard the in-flight instruction and redirect; the first fetch after release is address 0x0000.

Configuration
REQ-028 With macro PC_SEQ_LINK_EN defined, the block SHALL add:
- input link_take (1);
- output link_addr (16), a register.
REQ-029 With PC_SEQ_LINK_EN defined, an accept with jmp_take=1 and link_take=1 SHALL load link_addr <= incr_next_pc (pc+1) on the same edge that pc loads jmp_addr.
REQ-030 With PC_SEQ_LINK_EN defined, link_addr SHALL hold its value on every other edge.
REQ-031 Without PC_SEQ_LINK_EN, the link_take and link_addr ports and their register SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Sequential: release reset, imem_valid returns immediately, accept every HOLD -> imem_addr sequence 0x0000, 0x0001, 0x0002, with a fetch every 2 cycles.
REQ-033 Branch: pc=0x0010, accept with br_take=1, br_disp=0xFFFC -> incr_decr=1, incr_diff=0x0004, next fetch at 0x000C.
REQ-034 Jump over branch: accept with jmp_take=1, jmp_addr=0x1234 and br_take=1 -> next fetch at 0x1234.
REQ-035 Stall and wrap: pc=0xFFFF in HOLD, instr_ack=1 with stall=1 for 3 cycles -> pc stays 0xFFFF; stall drops -> next fetch at 0x0000.
REQ-036 Reset mid-operation: assert rst during FETCH at pc=0x0040 with imem_valid delayed -> instr_valid=0 and pc=0x0000 asynchronously; first fetch after release at 0x0000.
REQ-037 With PC_SEQ_LINK_EN defined: pc=0x0020, accept with jmp_take=1, link_take=1, jmp_addr=0x0100 -> link_addr=0x0021 and next fetch at 0x0100.
